regfile_master: RTL

Initiator for the 16×8 register-file access port. It turns the byte stream delivered by the bus-slave front end (start/stop framing, pointer byte, data bytes, read requests) into single-cycle chip-select/read-write cycles. It sits between the I2C slave byte layer and one port of the register file. The register file samples on the falling clock edge; this block drives on the rising edge.

---
 rtl/regfile_master.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_master.sv
// Byte-stream to register-file access sequencer: pointer load, single-cycle write/read strobes.
// Define REGM_AUTOINC_EN to post-increment the pointer after every register access.
module regfile_master #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_ck,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_byte,
  input  logic              i_rd_req,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_csn,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  input  logic [DATA_W-1:0] i_data
);

`ifdef REGM_AUTOINC_EN
  localparam logic [ADDR_W-1:0] PtrStep = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] PtrStep = ADDR_W'(0);
`endif

  typedef enum logic [2:0] {StIdle, StAddr, StAct, StWcyc, StRcyc} state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      ret_q      <= StIdle;
      ptr_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_valid_d = (state_q == StRcyc);
    rd_data_d  = (state_q == StRcyc) ? i_data : rd_data_q;
    case (state_q)
      StIdle: begin
        if (!i_stop && i_start) state_d = StAddr;
      end
      StAddr, StAct: begin
        if (i_stop) begin
          state_d = StIdle;
        end else if (i_start) begin
          state_d = StAddr;
        end else if (i_wr_valid) begin
          if (state_q == StAddr) begin
            ptr_d   = i_wr_byte[ADDR_W-1:0];
            state_d = StAct;
          end else begin
            addr_d  = ptr_q;
            data_d  = i_wr_byte;
            state_d = StWcyc;
          end
        end else if (i_rd_req) begin
          addr_d  = ptr_q;
          ret_d   = state_q;
          state_d = StRcyc;
        end
      end
      StWcyc, StRcyc: begin
        // A start/stop seen during the access replaces the normal return state.
        ptr_d = ptr_q + PtrStep;
        if (i_stop)                 state_d = StIdle;
        else if (i_start)           state_d = StAddr;
        else if (state_q == StWcyc) state_d = StAct;
        else                        state_d = ret_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ready    = (state_q == StAddr) || (state_q == StAct);
    o_csn      = !((state_q == StWcyc) || (state_q == StRcyc));
    o_rw       = (state_q != StWcyc);
    o_address  = addr_q;
    o_data     = data_q;
    o_rd_data  = rd_data_q;
    o_rd_valid = rd_valid_q;
  end

endmodule
